// File: rtl/garegga_sndcmd_tx.sv
// rtl/garegga_sndcmd_tx.sv - 68k-side sound command transmitter (FIFO -> SOUNDLATCH/Z80INT/ack handshake)
// Optional ack timeout built when SNDCMD_TIMEOUT_EN is defined.
module garegga_sndcmd_tx #(
  parameter int DEPTH      = 4,
  parameter int INT_HOLD   = 8,
  parameter int GAP_CYCLES = 4,
  parameter int TIMEOUT    = 65535
) (
  input  logic       CLK96,
  input  logic       RESET96,
  input  logic       CPU_WR,
  input  logic [7:0] CPU_DIN,
  input  logic       STATUS_CLR,
  input  logic       Z80_ACK,
  output logic [7:0] SOUNDLATCH,
  output logic       Z80INT,
  output logic       FULL,
  output logic       BUSY,
  output logic [7:0] STATUS
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [15:0] HOLD_LOAD = 16'(INT_HOLD - 1);
  localparam logic [15:0] GAP_LOAD  = 16'(GAP_CYCLES - 1);
  localparam bit NO_GAP = (GAP_CYCLES == 0);

  typedef enum logic [1:0] {S_IDLE, S_INT, S_WAIT_ACK, S_GAP} state_t;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  state_t        state, state_n;
  logic [15:0]   cnt, cnt_n;
  logic          ack_seen, ack_seen_n;
  logic          int_q, int_n;
  logic [7:0]    latch;
  logic          ovf;
  logic          tmo_bit;
  logic          empty, full, push, pop, ovf_set;
  logic [4:0]    count_w;
  logic [2:0]    count_sat;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign push    = CPU_WR && !full;
  assign ovf_set = CPU_WR && full;

`ifdef SNDCMD_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
  logic [15:0] tmo_cnt, tmo_cnt_n;
  logic        tmo, tmo_hit;
  assign tmo_bit = tmo;
`else
  assign tmo_bit = 1'b0;
`endif

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    ack_seen_n = ack_seen;
    int_n      = int_q;
    pop        = 1'b0;
`ifdef SNDCMD_TIMEOUT_EN
    tmo_cnt_n  = tmo_cnt;
    tmo_hit    = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          int_n      = 1'b1;
          cnt_n      = HOLD_LOAD;
          ack_seen_n = 1'b0;
          state_n    = S_INT;
        end
      end
      S_INT: begin
        if (Z80_ACK) ack_seen_n = 1'b1;
        if (cnt == '0) begin
          int_n = 1'b0;
          // An ack that arrived while Z80INT was still high skips the ack wait.
          if (ack_seen || Z80_ACK) begin
            state_n = NO_GAP ? S_IDLE : S_GAP;
            cnt_n   = GAP_LOAD;
          end else begin
            state_n = S_WAIT_ACK;
`ifdef SNDCMD_TIMEOUT_EN
            tmo_cnt_n = '0;
`endif
          end
        end else begin
          cnt_n = cnt - 16'd1;
        end
      end
      S_WAIT_ACK: begin
        if (Z80_ACK) begin
          state_n = NO_GAP ? S_IDLE : S_GAP;
          cnt_n   = GAP_LOAD;
        end
`ifdef SNDCMD_TIMEOUT_EN
        else if (tmo_cnt == TMO_LAST) begin
          tmo_hit = 1'b1;
          state_n = NO_GAP ? S_IDLE : S_GAP;
          cnt_n   = GAP_LOAD;
        end else begin
          tmo_cnt_n = tmo_cnt + 16'd1;
        end
`endif
      end
      S_GAP: begin
        if (cnt == '0) state_n = S_IDLE;
        else           cnt_n   = cnt - 16'd1;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Storage is not reset; reset only discards it via the pointers and count.
  always_ff @(posedge CLK96) begin
    if (push) mem[wr_ptr] <= CPU_DIN;
  end

  always_ff @(posedge CLK96 or posedge RESET96) begin
    if (RESET96) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      state    <= S_IDLE;
      cnt      <= '0;
      ack_seen <= 1'b0;
      int_q    <= 1'b0;
      latch    <= 8'h00;
      ovf      <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      ack_seen <= ack_seen_n;
      int_q    <= int_n;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        latch  <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (ovf_set)         ovf <= 1'b1;
      else if (STATUS_CLR) ovf <= 1'b0;
    end
  end

`ifdef SNDCMD_TIMEOUT_EN
  always_ff @(posedge CLK96 or posedge RESET96) begin
    if (RESET96) begin
      tmo_cnt <= '0;
      tmo     <= 1'b0;
    end else begin
      tmo_cnt <= tmo_cnt_n;
      if (tmo_hit)         tmo <= 1'b1;
      else if (STATUS_CLR) tmo <= 1'b0;
    end
  end
`endif

  assign count_w   = 5'(count);
  assign count_sat = (count_w > 5'd7) ? 3'd7 : count_w[2:0];

  assign SOUNDLATCH = latch;
  assign Z80INT     = int_q;
  assign FULL       = full;
  assign BUSY       = !empty || (state != S_IDLE);
  assign STATUS     = {BUSY, full, empty, ovf, tmo_bit, count_sat};

endmodule

// File: tb/tb_garegga_sndcmd_tx.sv
// tb/tb_garegga_sndcmd_tx.sv - scoreboard bench for garegga_sndcmd_tx
// Timeout scenario compiled only when SNDCMD_TIMEOUT_EN is defined.
module tb_garegga_sndcmd_tx;
  localparam int INT_HOLD   = 8;
  localparam int GAP_CYCLES = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cpu_wr = 1'b0;
  logic [7:0] cpu_din = 8'h00;
  logic       status_clr = 1'b0;
  logic       z80_ack = 1'b0;
  logic [7:0] soundlatch;
  logic       z80int, full, busy;
  logic [7:0] status;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];

  garegga_sndcmd_tx #(.DEPTH(4), .INT_HOLD(INT_HOLD), .GAP_CYCLES(GAP_CYCLES), .TIMEOUT(100)) dut (
    .CLK96(clk), .RESET96(rst), .CPU_WR(cpu_wr), .CPU_DIN(cpu_din),
    .STATUS_CLR(status_clr), .Z80_ACK(z80_ack),
    .SOUNDLATCH(soundlatch), .Z80INT(z80int), .FULL(full), .BUSY(busy), .STATUS(status)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] d, input bit accept);
    cpu_wr = 1'b1;
    cpu_din = d;
    if (accept) exp_q.push_back(d);
    tick();
    cpu_wr = 1'b0;
  endtask

  task automatic ack_pulse();
    z80_ack = 1'b1;
    tick();
    z80_ack = 1'b0;
  endtask

  task automatic wait_int(input logic lvl);
    int n = 0;
    while (z80int !== lvl && n < 500) begin
      tick();
      n++;
    end
    chk("wait_z80int_bound", (n < 500), 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 500) begin
      tick();
      n++;
    end
    chk("wait_idle_bound", (n < 500), 1);
  endtask

  task automatic drain(input int cmds);
    for (int i = 0; i < cmds; i++) begin
      wait_int(1'b1);
      wait_int(1'b0);
      ack_pulse();
    end
    wait_idle();
  endtask

  // Monitor: each Z80INT rising edge delivers one byte; checks order and pulse timing.
  bit prev_int = 1'b0;
  int low_cnt = 1000;
  int high_cnt = 0;
  always @(negedge clk) begin
    if (rst) begin
      prev_int = 1'b0;
      low_cnt = 1000;
      high_cnt = 0;
    end else if (z80int && !prev_int) begin
      chk("launch_expected", (exp_q.size() != 0), 1);
      if (exp_q.size() != 0) chk("soundlatch_order", soundlatch, exp_q.pop_front());
      chk("int_low_gap_ok", (low_cnt >= GAP_CYCLES + 1), 1);
      high_cnt = 1;
      prev_int = 1'b1;
    end else if (z80int) begin
      high_cnt++;
    end else if (prev_int) begin
      chk("int_high_cycles", high_cnt, INT_HOLD);
      low_cnt = 1;
      prev_int = 1'b0;
    end else begin
      low_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    chk("rst_soundlatch", soundlatch, 8'h00);
    chk("rst_z80int", z80int, 0);
    chk("rst_full", full, 0);
    chk("rst_busy", busy, 0);
    chk("rst_status", status, 8'h20);
    rst = 1'b0;
    tick(3);

    // Single command
    wr(8'h5A, 1);
    chk("t1_status_after_wr", status, 8'h81);
    chk("t1_int_not_yet", z80int, 0);
    tick();
    chk("t1_int_rise", z80int, 1);
    chk("t1_latch", soundlatch, 8'h5A);
    chk("t1_status_launched", status, 8'hA0);
    tick(7);
    chk("t1_int_last_high", z80int, 1);
    tick();
    chk("t1_int_fall", z80int, 0);
    chk("t1_busy_wait", busy, 1);
    tick(10);
    chk("t1_busy_before_ack", busy, 1);
    ack_pulse();
    tick(3);
    chk("t1_busy_gap", busy, 1);
    tick();
    chk("t1_busy_clear", busy, 0);
    chk("t1_status_idle", status, 8'h20);
    chk("t1_latch_hold", soundlatch, 8'h5A);

    // Burst of four
    wr(8'h01, 1);
    wr(8'h02, 1);
    wr(8'h03, 1);
    wr(8'h04, 1);
    chk("t2_full_after_4", full, 0);
    chk("t2_status", status, 8'h83);
    drain(4);

    // Overflow and sticky clear
    for (int i = 0; i < 5; i++) wr(8'h10 + 8'(i), 1);
    wr(8'h15, 0);
    chk("t3_status_ovf", status, 8'hD4);
    chk("t3_full", full, 1);
    status_clr = 1'b1;
    tick();
    status_clr = 1'b0;
    chk("t3_status_clr", status, 8'hC4);
    status_clr = 1'b1;
    wr(8'h16, 0);
    status_clr = 1'b0;
    chk("t3_set_wins", status, 8'hD4);
    status_clr = 1'b1;
    tick();
    status_clr = 1'b0;
    chk("t3_status_clr2", status, 8'hC4);
    drain(5);

    // Early ack during INT
    wr(8'hA1, 1);
    wr(8'hA2, 1);
    tick();
    ack_pulse();
    tick(5);
    chk("t4_int_held", z80int, 1);
    tick();
    chk("t4_int_fall", z80int, 0);
    tick(4);
    chk("t4_gap_low", z80int, 0);
    chk("t4_latch_stable", soundlatch, 8'hA1);
    tick();
    chk("t4_next_launch", z80int, 1);
    chk("t4_next_latch", soundlatch, 8'hA2);
    drain(1);

    // Reset during WAIT_ACK with two entries queued
    wr(8'hB1, 1);
    wr(8'hB2, 1);
    wr(8'hB3, 1);
    wait_int(1'b0);
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("t5_latch_async", soundlatch, 8'h00);
    chk("t5_int_async", z80int, 0);
    chk("t5_status_async", status, 8'h20);
    tick(2);
    rst = 1'b0;
    tick(30);
    chk("t5_no_int", z80int, 0);
    chk("t5_idle", busy, 0);
    wr(8'hC5, 1);
    drain(1);

`ifdef SNDCMD_TIMEOUT_EN
    // Ack timeout, then ack that lands on the timeout cycle
    wr(8'hD1, 1);
    wr(8'hD2, 1);
    wait_int(1'b1);
    wait_int(1'b0);
    tick(99);
    chk("t6_tmo_not_yet", status[3], 0);
    tick();
    chk("t6_tmo_set", status[3], 1);
    tick(4);
    chk("t6_gap_low", z80int, 0);
    tick();
    chk("t6_next_launch", z80int, 1);
    chk("t6_next_latch", soundlatch, 8'hD2);
    status_clr = 1'b1;
    tick();
    status_clr = 1'b0;
    chk("t6_tmo_clr", status[3], 0);
    wait_int(1'b0);
    tick(99);
    ack_pulse();
    chk("t6_ack_wins", status[3], 0);
    tick(2);
    chk("t6_ack_wins_later", status[3], 0);
    wait_idle();
`endif

    tick(5);
    chk("end_queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
